// File: rtl/dsp_coeff_loader.sv
// Streams coefficients into the DSP slice's two 8-entry coefficient banks (A then B) and tracks per-bank readiness.
// Optional running checksum output is enabled by defining DSP_COEFF_CHECKSUM_EN.
module dsp_coeff_loader #(
    parameter int COEFF_W = 18,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         bank_mask,
    input  logic               s_valid,
    input  logic [COEFF_W-1:0] s_data,
    output logic               s_ready,
    output logic [ADDR_W-1:0]  coeffbank_addr,
    output logic [COEFF_W-1:0] coeffbank_data,
    output logic               coeffbank_we,
    output logic               coeffbank_sel,
    output logic               busy,
    output logic               done,
    output logic               start_err,
    output logic               bank_a_ok,
    output logic               bank_b_ok
`ifdef DSP_COEFF_CHECKSUM_EN
    ,
    output logic [23:0]        coeff_checksum
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, FIN} state_t;

    state_t            state;
    state_t            next_state;
    logic              load_b_q;
    logic [ADDR_W-1:0] cnt;
    logic              accept;
    logic              start_accept;
    logic              last_word;

    assign accept       = s_valid && s_ready;
    assign start_accept = start && (state == IDLE);
    assign last_word    = (cnt == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // s_ready, busy and done depend on state alone so the upstream can never form a combinational loop through s_valid.
    always_comb begin
        next_state = state;
        s_ready    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (bank_mask[0]) begin
                        next_state = LOAD_A;
                    end else if (bank_mask[1]) begin
                        next_state = LOAD_B;
                    end else begin
                        next_state = FIN;
                    end
                end
            end
            LOAD_A: begin
                s_ready = 1'b1;
                if (accept && last_word) begin
                    next_state = load_b_q ? LOAD_B : FIN;
                end
            end
            LOAD_B: begin
                s_ready = 1'b1;
                if (accept && last_word) begin
                    next_state = FIN;
                end
            end
            FIN: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Write port is registered; addr/data/sel keep their last values whenever we is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_b_q       <= 1'b0;
            cnt            <= '0;
            coeffbank_addr <= '0;
            coeffbank_data <= '0;
            coeffbank_we   <= 1'b0;
            coeffbank_sel  <= 1'b0;
            start_err      <= 1'b0;
            bank_a_ok      <= 1'b0;
            bank_b_ok      <= 1'b0;
        end else begin
            coeffbank_we <= 1'b0;
            start_err    <= start && (state != IDLE);
            if (start_accept) begin
                load_b_q <= bank_mask[1];
                cnt      <= '0;
                if (bank_mask[0]) begin
                    bank_a_ok <= 1'b0;
                end
                if (bank_mask[1]) begin
                    bank_b_ok <= 1'b0;
                end
            end
            if (accept) begin
                coeffbank_we   <= 1'b1;
                coeffbank_addr <= cnt;
                coeffbank_data <= s_data;
                coeffbank_sel  <= (state == LOAD_A);
                cnt            <= last_word ? '0 : cnt + 1'b1;
                // The ok flag rises together with the write pulse of the bank's final entry.
                if (last_word) begin
                    if (state == LOAD_A) begin
                        bank_a_ok <= 1'b1;
                    end else begin
                        bank_b_ok <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef DSP_COEFF_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || start_accept) begin
            coeff_checksum <= '0;
        end else if (accept) begin
            coeff_checksum <= coeff_checksum + 24'(s_data);
        end
    end
`endif

endmodule

// File: tb/tb_dsp_coeff_loader.sv
// Randomized self-checking bench for dsp_coeff_loader; expected writes come from a per-sequence list of words
// and the bank order A-then-B.
module tb_dsp_coeff_loader;

    localparam int COEFF_W = 18;
    localparam int DEPTH   = 8;
    localparam int ADDR_W  = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [1:0]         bank_mask;
    logic               s_valid;
    logic [COEFF_W-1:0] s_data;
    logic               s_ready;
    logic [ADDR_W-1:0]  coeffbank_addr;
    logic [COEFF_W-1:0] coeffbank_data;
    logic               coeffbank_we;
    logic               coeffbank_sel;
    logic               busy;
    logic               done;
    logic               start_err;
    logic               bank_a_ok;
    logic               bank_b_ok;
`ifdef DSP_COEFF_CHECKSUM_EN
    logic [23:0]        coeff_checksum;
`endif

    int checkCount = 0;
    int errorCount = 0;

    // Reference state: bank readiness and the last write-port values the slice should be seeing.
    logic               expAOk;
    logic               expBOk;
    logic [ADDR_W-1:0]  expAddr;
    logic [COEFF_W-1:0] expData;
    logic               expSel;

    dsp_coeff_loader #(.COEFF_W(COEFF_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .bank_mask      (bank_mask),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_ready        (s_ready),
        .coeffbank_addr (coeffbank_addr),
        .coeffbank_data (coeffbank_data),
        .coeffbank_we   (coeffbank_we),
        .coeffbank_sel  (coeffbank_sel),
        .busy           (busy),
        .done           (done),
        .start_err      (start_err),
        .bank_a_ok      (bank_a_ok),
        .bank_b_ok      (bank_b_ok)
`ifdef DSP_COEFF_CHECKSUM_EN
        ,
        .coeff_checksum (coeff_checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [1:0] m, input logic v, input logic [COEFF_W-1:0] d);
        start     = st;
        bank_mask = m;
        s_valid   = v;
        s_data    = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkPort();
        checkOutput("bank_a_ok", 32'(bank_a_ok), 32'(expAOk));
        checkOutput("bank_b_ok", 32'(bank_b_ok), 32'(expBOk));
        checkOutput("addr", 32'(coeffbank_addr), 32'(expAddr));
        checkOutput("data", 32'(coeffbank_data), 32'(expData));
        checkOutput("sel", 32'(coeffbank_sel), 32'(expSel));
    endtask

    task automatic clearModel();
        expAOk  = 1'b0;
        expBOk  = 1'b0;
        expAddr = '0;
        expData = '0;
        expSel  = 1'b0;
    endtask

    // One complete sequence: idle junk, start, words with random gaps, optional start pulse while busy.
    task automatic runLoad(input logic [1:0] mask, input int gapPct, input int errAt, input bit countData);
        logic [COEFF_W-1:0] words[$];
        logic [23:0]        sum;
        int                 total;
        int                 idx;
        int                 wr;
        logic               pend;
        logic               errPend;
        logic               errUsed;
        logic               v;
        logic               st;

        total = DEPTH * $countones(mask);
        sum   = '0;
        for (int i = 0; i < total; i++) begin
            words.push_back(countData ? COEFF_W'(i + 1) : COEFF_W'($urandom));
            sum = sum + 24'(words[i]);
        end

        applyStimulus(1'b0, mask, 1'b1, COEFF_W'($urandom));
        tick();
        checkOutput("idle_ready", 32'(s_ready), 32'd0);
        checkOutput("idle_we", 32'(coeffbank_we), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        applyStimulus(1'b1, mask, 1'b0, '0);
        tick();
        if (mask[0]) expAOk = 1'b0;
        if (mask[1]) expBOk = 1'b0;
        checkOutput("start_busy", 32'(busy), 32'd1);
        checkOutput("start_err_idle", 32'(start_err), 32'd0);

        idx     = 0;
        wr      = 0;
        pend    = 1'b0;
        errPend = 1'b0;
        errUsed = 1'b0;
        while (idx < total || pend) begin
            if (pend) begin
                expSel  = mask[0] && (wr < DEPTH);
                expAddr = ADDR_W'(wr % DEPTH);
                expData = words[wr];
                if (wr % DEPTH == DEPTH - 1) begin
                    if (expSel) expAOk = 1'b1;
                    else        expBOk = 1'b1;
                end
                wr++;
            end
            checkOutput("we", 32'(coeffbank_we), 32'(pend));
            checkOutput("start_err", 32'(start_err), 32'(errPend));
            checkPort();
            if (idx < total) begin
                checkOutput("ready", 32'(s_ready), 32'd1);
                checkOutput("done_early", 32'(done), 32'd0);
                v       = ($urandom_range(99) >= gapPct);
                st      = (idx == errAt) && !errUsed;
                errUsed = errUsed || st;
                applyStimulus(st, 2'($urandom), v, v ? words[idx] : COEFF_W'($urandom));
                errPend = st;
                pend    = v;
                if (v) idx++;
            end else begin
                checkOutput("done", 32'(done), 32'd1);
                checkOutput("ready_fin", 32'(s_ready), 32'd0);
`ifdef DSP_COEFF_CHECKSUM_EN
                checkOutput("checksum", 32'(coeff_checksum), 32'(sum));
`endif
                applyStimulus(1'b0, mask, 1'b1, COEFF_W'($urandom));
                errPend = 1'b0;
                pend    = 1'b0;
            end
            tick();
        end

        if (total == 0) begin
            checkOutput("empty_done", 32'(done), 32'd1);
            checkOutput("empty_ready", 32'(s_ready), 32'd0);
            checkOutput("empty_we", 32'(coeffbank_we), 32'd0);
            checkPort();
`ifdef DSP_COEFF_CHECKSUM_EN
            checkOutput("empty_checksum", 32'(coeff_checksum), 32'd0);
`endif
            applyStimulus(1'b0, mask, 1'b1, COEFF_W'($urandom));
            tick();
        end

        checkOutput("end_done", 32'(done), 32'd0);
        checkOutput("end_busy", 32'(busy), 32'd0);
        checkOutput("end_we", 32'(coeffbank_we), 32'd0);
        checkOutput("end_start_err", 32'(start_err), 32'(errPend));
        checkPort();
        applyStimulus(1'b0, 2'b00, 1'b0, '0);
    endtask

    initial begin
        clearModel();
        reset = 1'b1;
        applyStimulus(1'b0, 2'b11, 1'b1, COEFF_W'($urandom));
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst_ready", 32'(s_ready), 32'd0);
            checkOutput("rst_we", 32'(coeffbank_we), 32'd0);
            checkOutput("rst_busy", 32'(busy), 32'd0);
            checkOutput("rst_done", 32'(done), 32'd0);
            checkOutput("rst_start_err", 32'(start_err), 32'd0);
            checkPort();
`ifdef DSP_COEFF_CHECKSUM_EN
            checkOutput("rst_checksum", 32'(coeff_checksum), 32'd0);
`endif
        end
        reset = 1'b0;
        applyStimulus(1'b0, 2'b00, 1'b0, '0);
        tick();

        runLoad(2'b11, 0, -1, 1'b1);
        runLoad(2'b10, 40, -1, 1'b0);
        runLoad(2'b01, 25, 3, 1'b0);
        runLoad(2'b00, 0, -1, 1'b0);
        for (int n = 0; n < 8; n++) begin
            runLoad(2'($urandom_range(3)), int'($urandom_range(60)), int'($urandom_range(20)) - 4, 1'b0);
        end

        // Abandon an A load after five accepted words.
        applyStimulus(1'b1, 2'b01, 1'b0, '0);
        tick();
        expAOk = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 2'b01, 1'b1, COEFF_W'($urandom));
            tick();
            checkOutput("abort_done", 32'(done), 32'd0);
        end
        reset = 1'b1;
        applyStimulus(1'b0, 2'b00, 1'b0, '0);
        tick();
        clearModel();
        reset = 1'b0;
        checkOutput("abort_done_rst", 32'(done), 32'd0);
        checkOutput("abort_we_rst", 32'(coeffbank_we), 32'd0);
        checkOutput("abort_busy_rst", 32'(busy), 32'd0);
        checkPort();
        tick();
        checkOutput("abort_done_after", 32'(done), 32'd0);
        checkPort();
        runLoad(2'b01, 30, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
